// File: rtl/lsu_align_if.sv
// lsu_align_if: request/response and word-memory bus of the load/store alignment unit
interface lsu_align_if #(parameter int ADDR_W = 7);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_type;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   modport master (
      output req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: splits byte-addressed loads/stores into aligned word accesses and reassembles load data
module lsu_align #(parameter int ADDR_W = 7) (
   input logic       clk,
   input logic       rstn,
   lsu_align_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;
   state_t            state, state_n;
   logic              we_q;
   logic [2:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       lo_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic [2:0]        n;
   logic [1:0]        off;
   logic [ADDR_W-3:0] w0, w1;
   logic              split;
   logic [3:0]        mask4;
   logic [7:0]        m_be;
   logic [63:0]       s_data;
   logic [63:0]       r_cat;
   logic [31:0]       r_word;
   logic [31:0]       ext;
   assign n      = (type_q == 3'd1 || type_q == 3'd2) ? 3'd2 :
                   (type_q == 3'd3 || type_q == 3'd4) ? 3'd1 : 3'd4;
   assign off    = addr_q[1:0];
   assign w0     = addr_q[ADDR_W-1:2];
   assign w1     = w0 + (ADDR_W-2)'(1);
   assign split  = ({1'b0, off} + n) > 3'd4;
   assign mask4  = (n == 3'd4) ? 4'hf : (n == 3'd2) ? 4'h3 : 4'h1;
   assign m_be   = {4'b0, mask4} << off;
   assign s_data = {32'b0, wdata_q} << {off, 3'b000};
   // the last read word arrives on mem_rdata in CAPT; a split load already holds its low word in lo_q
   assign r_cat  = split ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};
   assign r_word = 32'(r_cat >> {off, 3'b000});
   assign ext    = (type_q == 3'd1) ? {{16{r_word[15]}}, r_word[15:0]} :
                   (type_q == 3'd2) ? {16'b0, r_word[15:0]} :
                   (type_q == 3'd3) ? {{24{r_word[7]}}, r_word[7:0]} :
                   (type_q == 3'd4) ? {24'b0, r_word[7:0]} : r_word;
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end
   // request fields latched on handshake; low word of a split load captured in ACC1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_q    <= 1'b0;
         type_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            type_q  <= bus.req_type;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == ACC1 && !we_q) lo_q <= bus.mem_rdata;
      end
   end
   // registered completion pulse and extended load result
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= (state_n == RESP);
         rsp_rdata_q <= (state == CAPT) ? ext : '0;
      end
   end
   // next state and memory access drive
   always_comb begin
      state_n       = state;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: state_n = bus.req_valid ? ACC0 : IDLE;
         ACC0: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_be    = we_q ? m_be[3:0] : 4'hf;
            bus.mem_addr  = w0;
            bus.mem_wdata = we_q ? s_data[31:0] : '0;
            state_n       = split ? ACC1 : we_q ? RESP : CAPT;
         end
         ACC1: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_be    = we_q ? m_be[7:4] : 4'hf;
            bus.mem_addr  = w1;
            bus.mem_wdata = we_q ? s_data[63:32] : '0;
            state_n       = we_q ? RESP : CAPT;
         end
         CAPT:    state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule
